// File: rtl/axil_lsu_master.sv
// AXI4-Lite initiator for the load/store unit: one single-beat read or write in flight,
// with a watchdog that turns a silent responder into an error response.
module axil_lsu_master #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TO_W    = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW_W,
        S_B,
        S_RSP
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic [TO_W-1:0] wd_q, wd_d;

    logic ar_hs, aw_hs, w_hs, wd_expired;

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RSP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign araddr    = addr_q;
    assign arvalid   = (state_q == S_AR);
    assign rready    = (state_q == S_R);
    assign awaddr    = addr_q;
    assign awvalid   = (state_q == S_AW_W) && !aw_done_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign wvalid    = (state_q == S_AW_W) && !w_done_q;
    assign bready    = (state_q == S_B);

    assign ar_hs      = arvalid && arready;
    assign aw_hs      = awvalid && awready;
    assign w_hs       = wvalid && wready;
    assign wd_expired = (wd_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        wd_d      = wd_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    wd_d    = '0;
                    if (req_wen) begin
                        state_d   = S_AW_W;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d = S_AR;
                    end
                end
            end
            // A handshake landing on the final watchdog cycle still wins over the abort.
            S_AR: begin
                if (ar_hs) begin
                    state_d = S_R;
                    wd_d    = '0;
                end else if (wd_expired) begin
                    state_d = S_RSP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_R: begin
                if (rvalid) begin
                    state_d = S_RSP;
                    rdata_d = rdata;
                    err_d   = (rresp != 2'b00);
                end else if (wd_expired) begin
                    state_d = S_RSP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_AW_W: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = S_B;
                    wd_d    = '0;
                end else if (aw_hs || w_hs) begin
                    wd_d = '0;
                end else if (wd_expired) begin
                    state_d = S_RSP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_B: begin
                if (bvalid) begin
                    state_d = S_RSP;
                    rdata_d = '0;
                    err_d   = (bresp != 2'b00);
                end else if (wd_expired) begin
                    state_d = S_RSP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            wd_q      <= wd_d;
        end
    end

endmodule

// File: tb/tb_axil_lsu_master.sv
// Scoreboard bench for axil_lsu_master: a cycle-stepped responder drives the AXI side and
// expected LSU responses are queued at request time, then compared when the LSU takes them.
module tb_axil_lsu_master;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    axil_lsu_master #(.TIMEOUT(TO), .TO_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    string       cur_txn = "reset";
    logic [32:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s/%s: got %h expected %h", cur_txn, tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_axi_inputs();
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        rsp_ready = 1'b0; rdata = '0; rresp = '0; bresp = '0;
    endtask

    function automatic logic [31:0] axi_ctl();
        return 32'({arvalid, rready, awvalid, wvalid, bready});
    endfunction

    // ar_wait < 0 means the responder never accepts the read address
    task automatic run_txn(input string name, input bit wen, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] ws,
                           input int ar_wait, input int aw_wait, input int w_wait,
                           input logic [31:0] rd, input logic [1:0] resp,
                           input int rsp_hold, input int exp_lat,
                           input int exp_aw_cyc, input int exp_w_cyc, input bit exp_to);
        int          cyc, ar_cnt, aw_cnt, w_cnt, hold, rsp_first;
        bit          done;
        logic [31:0] held_rdata;
        logic        held_err;
        logic [32:0] e;
        cur_txn = name;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; hold = 0; rsp_first = -1; done = 0;
        held_rdata = '0; held_err = 1'b0;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = wd; req_wstrb = ws;
        exp_q.push_back({exp_to || (resp != 2'b00), (wen || exp_to) ? 32'h0 : rd});
        step();
        req_valid = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            arready = arvalid && (ar_wait >= 0) && (ar_cnt >= ar_wait);
            if (arvalid) begin
                chk("araddr", araddr, a);
                ar_cnt++;
            end
            rvalid = rready; rdata = rd; rresp = resp;
            awready = awvalid && (aw_cnt >= aw_wait);
            if (awvalid) begin
                chk("awaddr", awaddr, a);
                aw_cnt++;
            end
            wready = wvalid && (w_cnt >= w_wait);
            if (wvalid) begin
                chk("wdata", wdata, wd);
                chk("wstrb", 32'(wstrb), 32'(ws));
                w_cnt++;
            end
            bvalid = bready; bresp = resp;
            if (rsp_valid) begin
                if (rsp_first < 0) begin
                    rsp_first = cyc;
                    chk("latency", 32'(cyc), 32'(exp_lat));
                    chk("axi_idle_in_rsp", axi_ctl(), 32'd0);
                    held_rdata = rsp_rdata;
                    held_err = rsp_err;
                end else begin
                    chk("rdata_stable", rsp_rdata, held_rdata);
                    chk("err_stable", 32'(rsp_err), 32'(held_err));
                end
                chk("req_ready_in_rsp", 32'(req_ready), 32'd0);
                rsp_ready = (hold >= rsp_hold);
                hold++;
                if (rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_nonempty", 32'd0, 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, e[31:0]);
                        chk("rsp_err", 32'(rsp_err), 32'(e[32]));
                    end
                    done = 1;
                end
            end
            step();
            cyc++;
        end
        clear_axi_inputs();
        if (!done) begin
            chk("rsp_within_budget", 32'd0, 32'd1);
            exp_q.delete();
        end else begin
            chk("req_ready_after", 32'(req_ready), 32'd1);
            chk("rsp_valid_after", 32'(rsp_valid), 32'd0);
            chk("aw_cycles", 32'(aw_cnt), 32'(exp_aw_cyc));
            chk("w_cycles", 32'(w_cnt), 32'(exp_w_cyc));
        end
    endtask

    initial begin
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        clear_axi_inputs();
        step();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_axi_ctl", axi_ctl(), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        rst_n = 1'b1;
        step();

        //      name         wen addr          wdata         wstrb  arw aww ww rdata         resp  hold lat aw w  to
        run_txn("load_zw",   0, 32'h0000_1000, 32'h0,        4'h0,   0,  0, 0, 32'h1234_5678, 2'b00, 0,  3, 0, 0, 0);
        run_txn("store_aw3", 1, 32'ha000_03f8, 32'h0000_0041, 4'b0001, 0, 3, 0, 32'hdead_beef, 2'b00, 0,  6, 4, 1, 0);
        run_txn("store_zw",  1, 32'h0000_2004, 32'hcafe_f00d, 4'hf,   0,  0, 0, 32'h0,        2'b00, 0,  3, 1, 1, 0);
        run_txn("store_w2",  1, 32'h0000_2008, 32'h1111_2222, 4'b1100, 0, 0, 2, 32'h0,        2'b00, 0,  5, 1, 3, 0);
        run_txn("load_slverr", 0, 32'h0200_0000, 32'h0,      4'h0,   0,  0, 0, 32'h0bad_0bad, 2'b10, 0,  3, 0, 0, 0);
        run_txn("store_decerr", 1, 32'hf000_0000, 32'h5a5a_5a5a, 4'hf, 0, 0, 0, 32'h0,       2'b11, 0,  3, 1, 1, 0);
        run_txn("load_hold5", 0, 32'h0000_3000, 32'h0,       4'h0,   2,  0, 0, 32'h8765_4321, 2'b00, 5,  5, 0, 0, 0);
        run_txn("load_timeout", 0, 32'h4000_0000, 32'h0,     4'h0,  -1,  0, 0, 32'h7777_7777, 2'b00, 0, 17, 0, 0, 1);

        cur_txn = "stray_rb";
        rvalid = 1'b1; bvalid = 1'b1; rdata = 32'hffff_ffff; rresp = 2'b11; bresp = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("stray_req_ready", 32'(req_ready), 32'd1);
        end
        clear_axi_inputs();

        cur_txn = "reset_mid_aww";
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h0000_5000;
        req_wdata = 32'h1357_9bdf; req_wstrb = 4'hf;
        step();
        req_valid = 1'b0;
        step();
        chk("aww_pre_rst", 32'({awvalid, wvalid}), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("rst_async_axi", axi_ctl(), 32'd0);
        chk("rst_async_req_ready", 32'(req_ready), 32'd1);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_req_ready", 32'(req_ready), 32'd1);
            chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end

        run_txn("load_after_rst", 0, 32'h0000_6000, 32'h0, 4'h0, 0, 0, 0, 32'h0a0b_0c0d, 2'b00, 1, 3, 0, 0, 0);

        cur_txn = "end";
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
